bidir_bus_transceiver: RTL



---
 rtl/bidir_bus_transceiver.sv | 115 +++++++++++
 1 files changed

// File: rtl/bidir_bus_transceiver.sv
// WIDTH-bit bidirectional transceiver between buses A and B with a registered
// direction FSM and dead-time. Optional macro XCVR_REG_DATA_EN registers the data path.
module bidir_bus_transceiver #(
  parameter int WIDTH       = 8,
  parameter int TURN_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  inout  tri   [WIDTH-1:0] a_io,
  inout  tri   [WIDTH-1:0] b_io,
  input  logic             en_in,
  input  logic             dir_in,
  input  logic             sel,
  output tri               oe_out,
  output tri               dir_out,
  output logic             busy,
  output logic             act_ab,
  output logic             act_ba
);

  localparam int CNT_W = $clog2(TURN_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRIVE_AB = 2'd1,
    DRIVE_BA = 2'd2,
    TURN     = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             dir_q, dir_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      dir_q <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      dir_q <= dir_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    dir_nxt   = dir_q;
    case (state)
      IDLE: begin
        if (en_in) begin
          state_nxt = dir_in ? DRIVE_AB : DRIVE_BA;
          dir_nxt   = dir_in;
        end
      end
      DRIVE_AB: begin
        if (!en_in || !dir_in) begin
          state_nxt = TURN;
          cnt_nxt   = CNT_W'(TURN_CYCLES - 1);
        end
      end
      DRIVE_BA: begin
        if (!en_in || dir_in) begin
          state_nxt = TURN;
          cnt_nxt   = CNT_W'(TURN_CYCLES - 1);
        end
      end
      TURN: begin
        // Dead-time always runs to the end; the request only picks the target.
        if (cnt == '0) begin
          if (en_in) begin
            state_nxt = dir_in ? DRIVE_AB : DRIVE_BA;
            dir_nxt   = dir_in;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign act_ab = (state == DRIVE_AB);
  assign act_ba = (state == DRIVE_BA);
  assign busy   = (state == TURN);

  assign oe_out  = sel ? (act_ab | act_ba) : 1'bz;
  assign dir_out = sel ? dir_q : 1'bz;

`ifdef XCVR_REG_DATA_EN
  logic             src_a_p0;
  logic [WIDTH-1:0] data_p0;

  assign src_a_p0 = act_ab ? 1'b1 : (act_ba ? 1'b0 : dir_in);

  // Stage p0: source side captured every cycle; driven side replays it.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_p0 <= '0;
    end else begin
      data_p0 <= src_a_p0 ? a_io : b_io;
    end
  end

  assign b_io = act_ab ? data_p0 : {WIDTH{1'bz}};
  assign a_io = act_ba ? data_p0 : {WIDTH{1'bz}};
`else
  assign b_io = act_ab ? a_io : {WIDTH{1'bz}};
  assign a_io = act_ba ? b_io : {WIDTH{1'bz}};
`endif

endmodule
